mmio_probe: RTL and testbench

Bus-attached simulation and bring-up probe that replaces ad-hoc `$monitor`/fixed-delay test control around the CPU. It decodes a small address window on the CPU data bus, captures writes to N output channels into a tagged FIFO, and sequences CPU reset. It detects program completion through an exit register and detects hangs through a progress watchdog. It sits beside the RAM on the `addr`/`do`/`we` bus and reports `done`/`pass`/`timeout` to the bench or to board LEDs.

---
 rtl/mmio_probe_pkg.sv | 39 +++
 rtl/mmio_probe_sync_fifo.sv | 54 +++++
 rtl/mmio_probe.sv | 191 +++++++++++++++++++
 tb/tb_mmio_probe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_probe_pkg.sv
// mmio_probe_pkg: shared definitions for the MMIO bring-up probe.
// FSM state encoding, register offset helpers and STATUS bit positions.
package mmio_probe_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HUNG = 2'd3
  } probe_state_e;

  // STATUS register bit positions; bits above STAT_OVF read as 0
  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_DONE    = 2;
  localparam int STAT_PASS    = 3;
  localparam int STAT_TIMEOUT = 4;
  localparam int STAT_OVF     = 5;

  // EXIT sits right after the channel registers, STATUS right after EXIT
  function automatic int exit_offset(input int num_ch);
    return num_ch;
  endfunction

  function automatic int status_offset(input int num_ch);
    return num_ch + 1;
  endfunction

  // Window is the next power of two that holds all channels plus EXIT and STATUS
  function automatic int window_bits(input int num_ch);
    return $clog2(num_ch + 2);
  endfunction

  // Channel tag width, never narrower than one bit
  function automatic int tag_bits(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/mmio_probe_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with full/empty flags.
// A push while full is accepted when a pop happens in the same cycle.
// Reset is synchronous, active-low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_acc;
  logic             pop_acc;

  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign pop_acc  = pop_i && !empty_o;
  assign push_acc = push_i && (!full_o || pop_acc);
  // Head entry is visible without a read request
  assign dout_o   = mem_q[rd_ptr_q];

  // Storage write; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};
    end
  end

endmodule

// File: rtl/mmio_probe.sv
// mmio_probe: bus-attached bring-up probe. Decodes a small window on the CPU
// bus, streams channel writes through a tagged FIFO, sequences CPU reset and
// reports completion via an EXIT register or a progress watchdog.
// Optional build macro MMIO_PROBE_DISPLAY_EN adds simulation-only console
// output of popped entries and the final verdict.
module mmio_probe import mmio_probe_pkg::*; #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'hFF00,
  parameter int                NUM_CH     = 4,
  parameter int                FIFO_DEPTH = 8,
  parameter int                TIMEOUT    = 4096,
  parameter int                RST_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic                           we,
  output logic [DATA_W-1:0]              rdata,
  output logic                           hit,
  output logic                           cpu_rst,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [tag_bits(NUM_CH)-1:0]    out_ch,
  output logic [DATA_W-1:0]              out_data,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic                           overflow
);

  localparam int WIN_W  = window_bits(NUM_CH);
  localparam int CH_W   = tag_bits(NUM_CH);
  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [WIN_W-1:0]  EXIT_OFF  = WIN_W'(exit_offset(NUM_CH));
  localparam logic [WIN_W-1:0]  STAT_OFF  = WIN_W'(status_offset(NUM_CH));
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  probe_state_e      state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [WD_W-1:0]   wd_q;
  logic              cpu_rst_q, done_q, pass_q, timeout_q, overflow_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hit_q;

  logic              in_win;
  logic [WIN_W-1:0]  offset;
  logic              ch_wr, exit_wr, pop, push_ok;
  logic              fifo_full, fifo_empty;
  logic [CH_W+DATA_W-1:0] fifo_dout;
  logic [DATA_W-1:0] status_w;

  assign in_win  = (addr[ADDR_W-1:WIN_W] == BASE_ADDR[ADDR_W-1:WIN_W]);
  assign offset  = addr[WIN_W-1:0];
  // Window writes only take effect while the CPU is running
  assign ch_wr   = we && in_win && (offset < EXIT_OFF) && (state_q == ST_RUN);
  assign exit_wr = we && in_win && (offset == EXIT_OFF) && (state_q == ST_RUN);
  assign pop     = out_valid && out_ready;
  assign push_ok = !fifo_full || pop;

  sync_fifo #(
    .WIDTH (CH_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (rst),
    .push_i  (ch_wr),
    .din_i   ({offset[CH_W-1:0], wdata}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Stream outputs are forced to zero while nothing is queued
  assign out_valid          = !fifo_empty;
  assign {out_ch, out_data} = out_valid ? fifo_dout : '0;

  // STATUS register image and read-data selection for the current address
  always_comb begin
    status_w               = '0;
    status_w[STAT_EMPTY]   = fifo_empty;
    status_w[STAT_FULL]    = fifo_full;
    status_w[STAT_DONE]    = done_q;
    status_w[STAT_PASS]    = pass_q;
    status_w[STAT_TIMEOUT] = timeout_q;
    status_w[STAT_OVF]     = overflow_q;
    rdata_d                = (in_win && offset == STAT_OFF) ? status_w : '0;
  end

  // One-cycle registered read port
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      hit_q   <= in_win;
    end
  end

  // Run-control FSM: reset hold, run with watchdog, then terminal verdict
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_HOLD;
      hold_q     <= '0;
      wd_q       <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (ch_wr && !push_ok) overflow_q <= 1'b1;
      case (state_q)
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q   <= ST_RUN;
            cpu_rst_q <= 1'b0;
            wd_q      <= '0;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          // EXIT outranks watchdog expiry; any channel write counts as progress
          if (exit_wr) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= (wdata == '0);
          end else if (ch_wr) begin
            wd_q <= '0;
          end else if (TIMEOUT != 0) begin
            if (wd_q == WD_LAST) begin
              state_q   <= ST_HUNG;
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
            end else begin
              wd_q <= wd_q + WD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata    = rdata_q;
  assign hit      = hit_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;
  assign overflow = overflow_q;

`ifdef MMIO_PROBE_DISPLAY_EN
  logic              done_seen_q;
  logic [1:0]        fin_cnt_q;
  logic              fin_arm_q;
  logic [DATA_W-1:0] code_q;

  // Console trace of the capture stream and the final verdict
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_seen_q <= 1'b0;
      fin_arm_q   <= 1'b0;
      fin_cnt_q   <= '0;
      code_q      <= '0;
    end else begin
      if (pop) $display("ch%0d: %0d", out_ch, out_data);
      if (exit_wr) code_q <= wdata;
      done_seen_q <= done_q;
      if (done_q && !done_seen_q) begin
        if (timeout_q)   $display("TIMEOUT");
        else if (pass_q) $display("PASS");
        else             $display("FAIL code=%0d", code_q);
        fin_arm_q <= 1'b1;
      end
      if (fin_arm_q) begin
        fin_cnt_q <= fin_cnt_q + 2'd1;
        if (fin_cnt_q == 2'd1) $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mmio_probe.sv
// Testbench for mmio_probe: randomized bus traffic against a cycle-level
// behavioural model; a separate stream monitor checks the capture FIFO output.
module tb_mmio_probe;

  localparam int          NUM_CH = 4;
  localparam int          DEPTH  = 8;
  localparam int          TMO    = 16;
  localparam int          RC     = 4;
  localparam int          WIN    = 8;
  localparam logic [15:0] BASE   = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        we = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  rdata;
  logic        hit, cpu_rst, out_valid, done, pass, timeout, overflow;
  logic [1:0]  out_ch;
  logic [7:0]  out_data;

  mmio_probe #(
    .ADDR_W(16), .DATA_W(8), .BASE_ADDR(BASE), .NUM_CH(NUM_CH),
    .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .RST_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .hit(hit), .cpu_rst(cpu_rst),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .done(done), .pass(pass), .timeout(timeout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } entry_t;

  // Scoreboard of entries expected on the capture stream, oldest first
  entry_t exp_q[$];

  // Behavioural model state
  int         hold_left = RC;
  int         occ       = 0;
  int         idle      = 0;
  bit         m_done = 0, m_pass = 0, m_tmo = 0, m_ovf = 0, m_hit = 0;
  logic [7:0] m_rdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: the model consumes the inputs present at the edge,
  // then the DUT's registered outputs are compared 1 time unit after it.
  task automatic cyc();
    logic [15:0] a;
    logic [7:0]  w, st;
    logic        wv, rv, rdy;
    bit          inw, popm;
    int          off;
    entry_t      e;
    a = addr; w = wdata; wv = we; rv = rst; rdy = out_ready;
    @(posedge clk);
    #1;
    if (!rv) begin
      hold_left = RC; idle = 0; occ = 0;
      m_done = 0; m_pass = 0; m_tmo = 0; m_ovf = 0; m_hit = 0; m_rdata = 8'h00;
      exp_q.delete();
    end else begin
      off = int'(a) - int'(BASE);
      inw = (off >= 0) && (off < WIN);
      st = 8'h00;
      st[0] = (occ == 0); st[1] = (occ == DEPTH); st[2] = m_done;
      st[3] = m_pass;     st[4] = m_tmo;          st[5] = m_ovf;
      m_hit   = inw;
      m_rdata = (inw && off == NUM_CH + 1) ? st : 8'h00;
      popm = rdy && (occ > 0);
      if (hold_left > 0) begin
        hold_left--;
        idle = 0;
      end else if (!m_done) begin
        if (wv && inw && off < NUM_CH) begin
          idle = 0;
          if (occ < DEPTH || popm) begin
            e.ch = 2'(off); e.data = w;
            exp_q.push_back(e);
            occ++;
          end else begin
            m_ovf = 1;
          end
        end else if (wv && inw && off == NUM_CH) begin
          m_done = 1;
          m_pass = (w == 8'h00);
        end else begin
          idle++;
          if (idle == TMO) begin
            m_done = 1;
            m_tmo  = 1;
          end
        end
      end
      if (popm) occ--;
    end
    chk("cpu_rst", cpu_rst, hold_left > 0);
    chk("done", done, m_done);
    chk("pass", pass, m_pass);
    chk("timeout", timeout, m_tmo);
    chk("overflow", overflow, m_ovf);
    chk("hit", hit, m_hit);
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    addr = BASE + 16'(off); wdata = d; we = 1'b1;
    cyc();
    we = 1'b0; addr = 16'h0000;
  endtask

  task automatic rd(input int off);
    addr = BASE + 16'(off); we = 1'b0;
    cyc();
    addr = 16'h0000;
  endtask

  task automatic idle_n(input int n);
    we = 1'b0; addr = 16'h0000;
    repeat (n) cyc();
  endtask

  // Reset, release, and wait out the hold so the next cycle is the first RUN cycle
  task automatic do_reset();
    rst = 1'b0; we = 1'b0; addr = 16'h0000; out_ready = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    repeat (RC) cyc();
  endtask

  // Stream monitor: compares the FIFO head whenever the DUT presents an entry
  always @(negedge clk) begin
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (out_valid === 1'b1 && exp_q.size() != 0) begin
      chk("stream_ch", out_ch, exp_q[0].ch);
      chk("stream_data", out_data, exp_q[0].data);
      if (out_ready) exp_q.delete(0);
    end else if (out_valid !== 1'b1) begin
      chk("idle_ch", out_ch, 0);
      chk("idle_data", out_data, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    int act;

    // Reset values and hold length after release
    rst = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (cpu_rst == 1'b0) begin
        cnt = i;
        break;
      end
    end
    chk("hold_len", cnt, RC);

    // Capture of two tagged writes
    out_ready = 1'b1;
    wr(1, 8'h41);
    wr(3, 8'h42);
    idle_n(3);

    // Overflow: fill, drop one, then push+pop while full
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(int'($urandom_range(0, 3)), 8'($urandom));
    chk("ovf_set", overflow, 1);
    out_ready = 1'b1;
    wr(2, 8'h5A);
    out_ready = 1'b0;
    rd(NUM_CH + 1);
    chk("status_full_ovf", rdata, 8'h22);
    out_ready = 1'b1;
    idle_n(10);

    // Randomized traffic without EXIT writes
    do_reset();
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      act = int'($urandom_range(0, 99));
      if (act < 50) begin
        wr(int'($urandom_range(0, NUM_CH - 1)), 8'($urandom));
      end else if (act < 65) begin
        rd(int'($urandom_range(0, WIN - 1)));
      end else if (act < 72) begin
        wr(int'($urandom_range(NUM_CH + 1, WIN - 1)), 8'($urandom));
      end else if (act < 80) begin
        addr = 16'($urandom_range(0, 16'hFEFF)); wdata = 8'($urandom); we = 1'b1;
        cyc();
        we = 1'b0; addr = 16'h0000;
      end else begin
        idle_n(1);
      end
    end
    out_ready = 1'b1;
    idle_n(10);

    // EXIT with zero code
    do_reset();
    wr(NUM_CH, 8'h00);
    chk("exit0_done", done, 1);
    chk("exit0_pass", pass, 1);

    // EXIT with non-zero code, STATUS image, later writes ignored
    do_reset();
    wr(NUM_CH, 8'h05);
    chk("exit5_done", done, 1);
    chk("exit5_pass", pass, 0);
    rd(NUM_CH + 1);
    chk("exit5_status", rdata, 8'h05);
    out_ready = 1'b1;
    wr(0, 8'h77);
    idle_n(2);
    chk("post_exit_valid", out_valid, 0);

    // Watchdog expiry after TMO idle RUN cycles
    do_reset();
    idle_n(TMO - 1);
    chk("wd_not_yet", done, 0);
    idle_n(1);
    chk("wd_timeout", timeout, 1);
    chk("wd_done", done, 1);
    chk("wd_pass", pass, 0);

    // EXIT in the expiry cycle wins
    do_reset();
    idle_n(TMO - 1);
    wr(NUM_CH, 8'h00);
    chk("exit_wins_tmo", timeout, 0);
    chk("exit_wins_done", done, 1);

    // Mid-run reset with three queued entries
    do_reset();
    out_ready = 1'b0;
    wr(0, 8'h11);
    wr(1, 8'h22);
    wr(2, 8'h33);
    rst = 1'b0;
    cyc();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_cpu_rst", cpu_rst, 1);
    chk("midrst_done", done, 0);
    rst = 1'b1;
    repeat (RC + 2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
